// File: rtl/pwm_core.sv
// PWM generation engine fed by the AXI4-Lite register stage.
// Period, duty and prescale are double-buffered and reload only on a counter wrap.
module pwm_core #(
  parameter int CNT_WIDTH      = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      S_AXI_ACLK,
  input  logic                      S_AXI_ARESETN,
  input  logic                      ctrl_enable,
  input  logic                      ctrl_polarity,
  input  logic                      ctrl_update,
  input  logic [CNT_WIDTH-1:0]      cfg_period,
  input  logic [CNT_WIDTH-1:0]      cfg_duty,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  output logic                      pwm_out,
  output logic                      period_tick,
  output logic [CNT_WIDTH-1:0]      cnt_value,
  output logic                      update_pending
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] pres;
  logic [CNT_WIDTH-1:0]      period_sh;
  logic [CNT_WIDTH-1:0]      duty_sh;
  logic [PRESCALE_WIDTH-1:0] presc_sh;

  logic advance;
  logic wrap;
  logic active;

  assign advance = (pres == presc_sh);
  assign wrap    = advance && (cnt_value == period_sh);
  // cnt_value never exceeds period_sh, so a duty above the period simply stays active.
  assign active  = (cnt_value < duty_sh);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others, matching real flops.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state          <= IDLE;
      pres           <= '0;
      cnt_value      <= '0;
      period_tick    <= 1'b0;
      pwm_out        <= 1'b0;
      update_pending <= 1'b0;
      period_sh      <= '0;
      duty_sh        <= '0;
      presc_sh       <= '0;
    end else begin
      case (state)
        IDLE: begin
          pres           <= '0;
          cnt_value      <= '0;
          period_tick    <= 1'b0;
          update_pending <= 1'b0;
          pwm_out        <= ctrl_polarity;
          if (ctrl_enable) begin
            state     <= RUN;
            period_sh <= cfg_period;
            duty_sh   <= cfg_duty;
            presc_sh  <= cfg_prescale;
          end
        end

        RUN: begin
          if (!ctrl_enable) begin
            // Disable wins over a coincident wrap: no shadow load on the way out.
            state          <= IDLE;
            pres           <= '0;
            cnt_value      <= '0;
            period_tick    <= 1'b0;
            update_pending <= 1'b0;
            pwm_out        <= ctrl_polarity;
          end else begin
            pwm_out     <= active ^ ctrl_polarity;
            period_tick <= wrap;
            pres        <= advance ? '0 : pres + PRESCALE_WIDTH'(1);
            if (advance) begin
              cnt_value <= wrap ? '0 : cnt_value + CNT_WIDTH'(1);
            end

            if (wrap && (update_pending || ctrl_update)) begin
              period_sh      <= cfg_period;
              duty_sh        <= cfg_duty;
              presc_sh       <= cfg_prescale;
              update_pending <= 1'b0;
            end else if (ctrl_update) begin
              update_pending <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pwm_core.md
Name: pwm_core

Overview:
- PWM generation engine that sits directly downstream of the AXI4-Lite register stage of the PWM controller.
- Consumes the control, period, duty and prescale register values plus an update strobe, and produces the PWM waveform and status.
- Duty and period changes take effect glitch-free: double-buffered shadow registers load only at period boundaries.
- Single clock domain, shared with the AXI register stage.

Parameters:
CNT_WIDTH, 32, width of the period, duty and counter values
PRESCALE_WIDTH, 16, width of the clock prescaler

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low
ctrl_enable  in  1  level; 1 = run, 0 = idle
ctrl_polarity  in  1  0 = active-high output, 1 = active-low output
ctrl_update  in  1  single-cycle strobe; request shadow reload from cfg_*
cfg_period  in  CNT_WIDTH  terminal count; counter runs 0..cfg_period
cfg_duty  in  CNT_WIDTH  active while cnt < duty
cfg_prescale  in  PRESCALE_WIDTH  counter advances every (prescale+1) clocks
pwm_out  out  1  registered PWM output
period_tick  out  1  one-cycle pulse on counter wrap
cnt_value  out  CNT_WIDTH  current period counter
update_pending  out  1  reload requested, not yet applied

Behaviour:
Reset (S_AXI_ARESETN=0, takes effect immediately):
- state=IDLE.
- pwm_out, period_tick, cnt_value, update_pending and prescale counter all 0.
- period_sh, duty_sh, presc_sh all 0.

States: IDLE, RUN.
- IDLE:
  - cnt=0, pres=0, period_tick=0.
  - pwm_out = ctrl_polarity (inactive level), registered.
  - ctrl_update ignored; update_pending forced 0.
- IDLE->RUN: on the edge where ctrl_enable is sampled 1.
  - Same edge: shadows load from cfg_*, cnt=0, pres=0.
- RUN, every clock:
  - If pres == presc_sh: pres=0 and advance=1; else pres+1.
  - On advance with cnt == period_sh: cnt=0, period_tick=1 for that one cycle, wrap event.
  - On advance otherwise: cnt+1.
- RUN->IDLE: on the edge where ctrl_enable is sampled 0.
  - cnt, pres, period_tick and update_pending cleared.
  - pwm_out at inactive level from that edge on.

Output timing:
- pwm_out(t+1) = (cnt(t) < duty_sh) XOR ctrl_polarity, evaluated in RUN.
- pwm_out therefore lags cnt_value by exactly 1 clock.
- The first active cycle appears 1 clock after the enabling edge.

Period and duty:
- Period length = (period_sh+1)*(presc_sh+1) clocks.
- Active length = min(duty_sh, period_sh+1)*(presc_sh+1) clocks.
- duty_sh = 0: constantly inactive.
- duty_sh > period_sh: constantly active.
- period_sh = 0: tick on every advance.
- Compare is unsigned, full CNT_WIDTH; no overflow is possible because cnt never exceeds period_sh.

Shadow update:
- ctrl_update in RUN sets update_pending.
- At the next wrap event, period_sh/duty_sh/presc_sh load cfg_* and update_pending clears.
- ctrl_update in the same cycle as a wrap: load happens at that wrap; update_pending stays 0.
- Multiple strobes before a wrap: single load of the latest cfg_* values.
- cfg_* changes without ctrl_update are never applied in RUN.

Other boundaries:
- ctrl_enable deasserted in the same cycle as a wrap: IDLE wins; no shadow load.
- Reset mid-run: waveform aborts immediately; after reset release the block is in IDLE, waiting for ctrl_enable.

Test Plan:
- period=9, duty=3, prescale=0, pol=0, enable -> pwm_out high 3 clocks / low 7; period_tick every 10 clocks; cnt_value cycles 0..9.
- period=4, duty=2, prescale=1 -> pwm_out high 4 clocks / low 6; period_tick every 10 clocks; cnt_value steps every 2 clocks.
- Running period=9, duty=3; set cfg_duty=7 and pulse ctrl_update at cnt=5 -> current period still 3 high; update_pending=1 until wrap; next period 7 high; update_pending=0 after wrap.
- duty=0 -> pwm_out constant 0; duty=12 with period=9 -> constant 1; repeat with pol=1 -> both results inverted, and idle level =1.
- Drop ctrl_enable at cnt=4 -> pwm_out inactive next cycle, cnt_value=0, no tick; re-enable -> waveform restarts from cnt=0 with current cfg_*.
- Assert S_AXI_ARESETN=0 mid-period, between clock edges -> pwm_out, period_tick, cnt_value and update_pending all 0 immediately; after release the block stays IDLE until enable.
